// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter
//   Shares one byte-wide SPI master engine between NUM_REQ requesters.
//   Picks a requester round-robin and drives its active-low slave select.
//   Sends its 1-4 byte burst one byte at a time, LSB byte first.
//   Returns the received bytes assembled into rdata_o.
//
// Ports
//   HCLK, HRESETn    clock, synchronous active-low reset
//   req_i            per-requester request level, held until its done_o pulse
//   len_i            per-requester byte count (3 bits each, clamped to 1..4)
//   wdata_i          per-requester write word (32 bits each)
//   ss_idx_i         per-requester slave-select index (SS_IDX_W bits each)
//   gnt_o            one-hot grant, held for the whole burst
//   done_o           one-cycle completion pulse to the requester just served
//   rdata_o          read word of the last completed burst, upper unused bytes 0
//   busy_o           high whenever the FSM is not idle
//   spi_start_o      one-cycle start pulse to the SPI master
//   spi_tx_data_o    byte to send, valid while spi_start_o is high
//   spi_rx_data_i    byte received by the master
//   spi_ready_i      master idle/ready
//   spi_ss_o         active-low slave selects
//   dbg_state_o      current FSM state encoding, for observation only
//
// Handshakes
//   Requester side: req_i is a level. It is sampled only while idle and is
//   ignored once the burst has been granted. done_o marks the end of the burst.
//   Master side: one spi_start_o pulse is sent per byte. The byte is treated as
//   finished when spi_ready_i first drops low after the pulse and then returns
//   high. spi_rx_data_i is captured on that rising return of spi_ready_i.
module spi_txn_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int SS_WIDTH = 32,
   parameter int SS_IDX_W = 5
) (
   input  logic                         HCLK,
   input  logic                         HRESETn,
   input  logic [NUM_REQ-1:0]           req_i,
   input  logic [3*NUM_REQ-1:0]         len_i,
   input  logic [32*NUM_REQ-1:0]        wdata_i,
   input  logic [SS_IDX_W*NUM_REQ-1:0]  ss_idx_i,
   output logic [NUM_REQ-1:0]           gnt_o,
   output logic [NUM_REQ-1:0]           done_o,
   output logic [31:0]                  rdata_o,
   output logic                         busy_o,
   output logic                         spi_start_o,
   output logic [7:0]                   spi_tx_data_o,
   input  logic [7:0]                   spi_rx_data_i,
   input  logic                         spi_ready_i,
   output logic [SS_WIDTH-1:0]          spi_ss_o,
   output logic [2:0]                   dbg_state_o
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_COMPLETE  = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic [PTR_W-1:0]      ptr_q, ptr_d;
   logic [NUM_REQ-1:0]    gnt_q, gnt_d;
   logic [NUM_REQ-1:0]    done_q, done_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [2:0]            len_q, len_d;
   logic [2:0]            cnt_q, cnt_d;
   logic [31:0]           shadow_q, shadow_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  start_q, start_d;
   logic [7:0]            tx_q, tx_d;
   logic [SS_WIDTH-1:0]   ss_q, ss_d;

   // Per-requester fields unpacked for indexing by the winner.
   logic [2:0]            len_a   [NUM_REQ];
   logic [31:0]           wdata_a [NUM_REQ];
   logic [SS_IDX_W-1:0]   ss_a    [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign len_a[g]   = len_i[g*3 +: 3];
      assign wdata_a[g] = wdata_i[g*32 +: 32];
      assign ss_a[g]    = ss_idx_i[g*SS_IDX_W +: SS_IDX_W];
   end

   // Round-robin winner. Scanning offsets from farthest to nearest lets the
   // nearest set request after the pointer overwrite the others.
   logic [PTR_W-1:0]      win_idx;
   logic [PTR_W-1:0]      cand;
   logic                  any_req;
   logic [2:0]            win_len;
   logic [SS_WIDTH-1:0]   win_ss;
   logic [31:0]           tx_shift;

   always_comb begin
      win_idx = '0;
      cand    = '0;
      any_req = |req_i;
      for (int off = NUM_REQ; off >= 1; off--) begin
         cand = PTR_W'((int'(ptr_q) + off) % NUM_REQ);
         if (req_i[cand]) win_idx = cand;
      end
      // Clamp the length: 0 is sent as 1 byte, and 5..7 are sent as 4 bytes.
      if (len_a[win_idx] == 3'd0)      win_len = 3'd1;
      else if (len_a[win_idx] > 3'd4)  win_len = 3'd4;
      else                             win_len = len_a[win_idx];
      // An index beyond the bus width matches no bit and selects no slave.
      win_ss = '1;
      for (int i = 0; i < SS_WIDTH; i++) begin
         if (int'(ss_a[win_idx]) == i) win_ss[i] = 1'b0;
      end
   end

   // FSM process 1: state register
   always_ff @(posedge HCLK) begin
      if (!HRESETn) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // FSM process 2: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:      if (any_req && spi_ready_i) state_d = ST_START;
         ST_START:     state_d = ST_WAIT_BUSY;
         ST_WAIT_BUSY: if (!spi_ready_i) state_d = ST_WAIT_DONE;
         ST_WAIT_DONE: if (spi_ready_i) begin
                          if ((cnt_q + 3'd1) < len_q) state_d = ST_START;
                          else                        state_d = ST_COMPLETE;
                       end
         ST_COMPLETE:  state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   // FSM process 3: outputs and datapath next values
   always_comb begin
      ptr_d    = ptr_q;
      gnt_d    = gnt_q;
      done_d   = '0;
      wdata_d  = wdata_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      rdata_d  = rdata_q;
      start_d  = 1'b0;
      tx_d     = 8'h00;
      ss_d     = ss_q;
      tx_shift = wdata_q >> {cnt_q[1:0], 3'b000};
      busy_o      = (state_q != ST_IDLE);
      dbg_state_o = state_q;
      case (state_q)
         ST_IDLE: if (any_req && spi_ready_i) begin
            ptr_d    = win_idx;
            gnt_d    = NUM_REQ'(1) << win_idx;
            wdata_d  = wdata_a[win_idx];
            len_d    = win_len;
            cnt_d    = 3'd0;
            shadow_d = 32'h0;
            ss_d     = win_ss;
         end
         // The start pulse and its byte are registered, so they appear in
         // the cycle after START, one cycle after the grant.
         ST_START: begin
            start_d = 1'b1;
            tx_d    = tx_shift[7:0];
         end
         ST_WAIT_DONE: if (spi_ready_i) begin
            case (cnt_q[1:0])
               2'd0: shadow_d[7:0]   = spi_rx_data_i;
               2'd1: shadow_d[15:8]  = spi_rx_data_i;
               2'd2: shadow_d[23:16] = spi_rx_data_i;
               default: shadow_d[31:24] = spi_rx_data_i;
            endcase
            cnt_d = cnt_q + 3'd1;
            // On the last byte, the COMPLETE cycle sees the finished result.
            // rdata is updated, the grant and SS are released, and done pulses.
            if ((cnt_q + 3'd1) >= len_q) begin
               rdata_d = shadow_d;
               gnt_d   = '0;
               ss_d    = '1;
               done_d  = gnt_q;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         ptr_q    <= PTR_W'(NUM_REQ - 1);
         gnt_q    <= '0;
         done_q   <= '0;
         wdata_q  <= 32'h0;
         len_q    <= 3'd1;
         cnt_q    <= 3'd0;
         shadow_q <= 32'h0;
         rdata_q  <= 32'h0;
         start_q  <= 1'b0;
         tx_q     <= 8'h00;
         ss_q     <= '1;
      end else begin
         ptr_q    <= ptr_d;
         gnt_q    <= gnt_d;
         done_q   <= done_d;
         wdata_q  <= wdata_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         rdata_q  <= rdata_d;
         start_q  <= start_d;
         tx_q     <= tx_d;
         ss_q     <= ss_d;
      end
   end

   assign gnt_o         = gnt_q;
   assign done_o        = done_q;
   assign rdata_o       = rdata_q;
   assign spi_start_o   = start_q;
   assign spi_tx_data_o = tx_q;
   assign spi_ss_o      = ss_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// tb_spi_txn_arbiter
//   Directed bench for spi_txn_arbiter.
//   A behavioural SPI master answers each start pulse. It holds spi_ready_i
//   low for busy_cycles, then returns the next byte from rx_q. Transmitted
//   bytes are logged and compared against exp_q. A monitor watches grant
//   one-hotness, slave-select correctness and the SS-high gap between bursts.
module tb_spi_txn_arbiter;

   localparam int NUM_REQ = 4;

   logic          HCLK = 1'b0;
   logic          HRESETn = 1'b0;
   logic [3:0]    req_i = '0;
   logic [2:0]    len_a [NUM_REQ];
   logic [31:0]   wdata_a [NUM_REQ];
   logic [4:0]    ss_a [NUM_REQ];
   logic [11:0]   len_i;
   logic [127:0]  wdata_i;
   logic [19:0]   ss_idx_i;
   logic [3:0]    gnt_o, done_o;
   logic [31:0]   rdata_o;
   logic          busy_o, spi_start_o;
   logic [7:0]    spi_tx_data_o;
   logic [7:0]    spi_rx_data_i = 8'h00;
   logic          spi_ready_i = 1'b1;
   logic [31:0]   spi_ss_o;
   logic [2:0]    dbg_state_o;

   always #5 HCLK = ~HCLK;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
      assign len_i[g*3 +: 3]    = len_a[g];
      assign wdata_i[g*32 +: 32] = wdata_a[g];
      assign ss_idx_i[g*5 +: 5] = ss_a[g];
   end

   spi_txn_arbiter #(.NUM_REQ(4), .SS_WIDTH(32), .SS_IDX_W(5)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .req_i(req_i), .len_i(len_i),
      .wdata_i(wdata_i), .ss_idx_i(ss_idx_i), .gnt_o(gnt_o), .done_o(done_o),
      .rdata_o(rdata_o), .busy_o(busy_o), .spi_start_o(spi_start_o),
      .spi_tx_data_o(spi_tx_data_o), .spi_rx_data_i(spi_rx_data_i),
      .spi_ready_i(spi_ready_i), .spi_ss_o(spi_ss_o), .dbg_state_o(dbg_state_o)
   );

   int          tests_run = 0;
   int          fail_cnt  = 0;
   logic [7:0]  exp_q [$];
   logic [7:0]  rx_q [$];
   logic [7:0]  tx_log [$];
   int          busy_cycles = 2;
   int          busy_left = 0;
   int          start_cnt = 0;
   int          onehot_err = 0, ss_err = 0, gap_err = 0;
   int          done_cnt [NUM_REQ] = '{0, 0, 0, 0};
   int          gnt_log [$];
   logic [3:0]  prev_gnt = '0;
   logic [31:0] prev_ss = '1;

   // Behavioural SPI master, driven on the falling edge.
   always @(negedge HCLK) begin
      if (!HRESETn) begin
         spi_ready_i = 1'b1;
         busy_left = 0;
      end else begin
         if (spi_start_o) start_cnt++;
         if (spi_start_o && spi_ready_i) begin
            tx_log.push_back(spi_tx_data_o);
            spi_ready_i = 1'b0;
            spi_rx_data_i = 8'hEE;
            busy_left = busy_cycles;
         end else if (!spi_ready_i) begin
            if (busy_left > 1) busy_left--;
            else begin
               spi_ready_i = 1'b1;
               spi_rx_data_i = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
            end
         end
      end
   end

   // Protocol monitor
   always @(negedge HCLK) begin
      logic [31:0] exp_ss;
      exp_ss = '1;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (done_o[i] === 1'b1) done_cnt[i]++;
         if (gnt_o[i] === 1'b1) exp_ss = ~(32'd1 << ss_a[i]);
      end
      if (HRESETn) begin
         if ((gnt_o & (gnt_o - 4'd1)) != 4'd0) onehot_err++;
         if (spi_ss_o !== exp_ss) ss_err++;
         if (gnt_o != 4'd0 && prev_gnt == 4'd0) begin
            for (int i = 0; i < NUM_REQ; i++) if (gnt_o[i]) gnt_log.push_back(i);
            if (prev_ss !== '1) gap_err++;
         end
      end
      prev_gnt = gnt_o;
      prev_ss  = spi_ss_o;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         fail_cnt++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_tx(input string tag);
      check({tag, "_count"}, tx_log.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         check({tag, "_byte"}, (i < tx_log.size()) ? {24'h0, tx_log[i]} : 32'hDEAD0000,
               {24'h0, exp_q[i]});
   endtask

   task automatic wait_done(input int idx, input int maxc, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < maxc && !ok; c++) begin
         @(negedge HCLK);
         if (done_o[idx] === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic wait_done_any(input int maxc, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < maxc && !ok; c++) begin
         @(negedge HCLK);
         if (done_o != 4'd0) ok = 1'b1;
      end
   endtask

   task automatic wait_tx(input int n, input int maxc, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < maxc && !ok; c++) begin
         @(negedge HCLK);
         if (tx_log.size() >= n) ok = 1'b1;
      end
   endtask

   task automatic do_reset();
      HRESETn = 1'b0;
      req_i = '0;
      repeat (3) @(negedge HCLK);
      HRESETn = 1'b1;
      rx_q.delete();
   endtask

   initial begin
      bit ok;
      int d0;
      for (int i = 0; i < NUM_REQ; i++) begin
         len_a[i] = 3'd1; wdata_a[i] = 32'h0; ss_a[i] = 5'd0;
      end

      // Reset values, sampled while reset is held
      HRESETn = 1'b0;
      repeat (3) @(negedge HCLK);
      check("rst_gnt", gnt_o, 0);
      check("rst_done", done_o, 0);
      check("rst_rdata", rdata_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_start", spi_start_o, 0);
      check("rst_tx", spi_tx_data_o, 0);
      check("rst_ss", spi_ss_o, 32'hFFFFFFFF);
      check("rst_state", dbg_state_o, 0);
      HRESETn = 1'b1;

      // Single requester, 2 bytes, grant latency
      ss_a[0] = 5'd3; len_a[0] = 3'd2; wdata_a[0] = 32'h0000A55A;
      rx_q = '{8'h11, 8'h22}; exp_q = '{8'h5A, 8'hA5}; tx_log.delete();
      @(negedge HCLK); req_i[0] = 1'b1;
      @(negedge HCLK);
      check("lat_gnt", gnt_o, 4'b0001);
      check("lat_nostart", spi_start_o, 0);
      check("lat_ss", spi_ss_o, 32'hFFFFFFF7);
      @(negedge HCLK);
      check("lat_start", spi_start_o, 1);
      check("lat_tx", spi_tx_data_o, 32'h5A);
      wait_done(0, 200, ok);
      check("t1_done_seen", ok, 1);
      req_i[0] = 1'b0;
      repeat (2) @(negedge HCLK);
      check("t1_rdata", rdata_o, 32'h00002211);
      check("t1_idle", busy_o, 0);
      check("t1_done_cnt", done_cnt[0], 1);
      check_tx("t1_tx");

      // Round-robin between requesters 0 and 2 from a fresh pointer
      do_reset();
      len_a[0] = 3'd1; len_a[2] = 3'd1; ss_a[2] = 5'd7;
      gnt_log.delete(); tx_log.delete();
      req_i = 4'b0101;
      for (int n = 0; n < 4; n++) begin
         wait_done_any(200, ok);
         check("rr_done_seen", ok, 1);
      end
      req_i = '0;
      repeat (3) @(negedge HCLK);
      check("rr_grants", gnt_log.size(), 4);
      for (int n = 0; n < 4; n++)
         check("rr_order", (n < gnt_log.size()) ? gnt_log[n] : -1, (n % 2 == 0) ? 0 : 2);
      check("rr_done2", done_cnt[2], 2);

      // Length clamp: 0 sends one byte
      len_a[1] = 3'd0; wdata_a[1] = 32'h12345678; ss_a[1] = 5'd0;
      rx_q = '{8'h9C}; exp_q = '{8'h78}; tx_log.delete(); start_cnt = 0;
      req_i[1] = 1'b1;
      wait_done(1, 200, ok);
      check("len0_done_seen", ok, 1);
      req_i[1] = 1'b0;
      repeat (2) @(negedge HCLK);
      check_tx("len0_tx");
      check("len0_rdata", rdata_o, 32'h0000009C);
      check("len0_starts", start_cnt, 1);

      // Length clamp: 7 sends four bytes, highest slave index
      len_a[3] = 3'd7; wdata_a[3] = 32'hDDCCBBAA; ss_a[3] = 5'd31;
      rx_q = '{8'h01, 8'h02, 8'h03, 8'h04};
      exp_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD}; tx_log.delete();
      req_i[3] = 1'b1;
      wait_done(3, 300, ok);
      check("len7_done_seen", ok, 1);
      req_i[3] = 1'b0;
      repeat (2) @(negedge HCLK);
      check_tx("len7_tx");
      check("len7_rdata", rdata_o, 32'h04030201);

      // Request dropped after the first byte
      busy_cycles = 3;
      len_a[1] = 3'd4; wdata_a[1] = 32'h44332211;
      rx_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
      exp_q = '{8'h11, 8'h22, 8'h33, 8'h44}; tx_log.delete();
      req_i[1] = 1'b1;
      wait_tx(1, 100, ok);
      check("drop_first_byte", ok, 1);
      req_i[1] = 1'b0;
      wait_done(1, 300, ok);
      check("drop_done_seen", ok, 1);
      repeat (2) @(negedge HCLK);
      check_tx("drop_tx");
      check("drop_rdata", rdata_o, 32'hA3A2A1A0);

      // Slow master: ready low for 20 cycles per byte
      busy_cycles = 20;
      len_a[2] = 3'd2; wdata_a[2] = 32'h0000BEEF;
      rx_q = '{8'h5C, 8'hC5}; exp_q = '{8'hEF, 8'hBE};
      tx_log.delete(); start_cnt = 0;
      req_i[2] = 1'b1;
      wait_done(2, 500, ok);
      check("slow_done_seen", ok, 1);
      req_i[2] = 1'b0;
      repeat (2) @(negedge HCLK);
      check("slow_starts", start_cnt, 2);
      check_tx("slow_tx");
      check("slow_rdata", rdata_o, 32'h0000C55C);

      // Reset during the second byte of a 3-byte burst
      busy_cycles = 5;
      len_a[0] = 3'd3; wdata_a[0] = 32'h00654321; ss_a[0] = 5'd3;
      rx_q = '{8'h71, 8'h72, 8'h73}; tx_log.delete();
      req_i[0] = 1'b1;
      wait_tx(2, 200, ok);
      check("rst_mid_second_byte", ok, 1);
      repeat (2) @(negedge HCLK);
      check("rst_mid_busy_before", busy_o, 1);
      d0 = done_cnt[0];
      HRESETn = 1'b0; req_i = '0;
      @(negedge HCLK);
      check("rst_mid_ss", spi_ss_o, 32'hFFFFFFFF);
      check("rst_mid_gnt", gnt_o, 0);
      check("rst_mid_done", done_o, 0);
      check("rst_mid_busy", busy_o, 0);
      @(negedge HCLK);
      HRESETn = 1'b1; rx_q.delete();
      repeat (2) @(negedge HCLK);
      check("rst_mid_no_done", done_cnt[0], d0);
      len_a[0] = 3'd1; len_a[1] = 3'd1;
      gnt_log.delete();
      req_i = 4'b0011;
      wait_done_any(200, ok);
      check("post_rst_done_seen", ok, 1);
      check("post_rst_first", (gnt_log.size() > 0) ? gnt_log[0] : -1, 0);
      req_i[0] = 1'b0;
      wait_done(1, 200, ok);
      check("post_rst_req1_done", ok, 1);
      req_i = '0;
      repeat (3) @(negedge HCLK);

      // Whole-run protocol monitors
      check("mon_onehot", onehot_err, 0);
      check("mon_ss", ss_err, 0);
      check("mon_ss_gap", gap_err, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
